riscv_core_reg_scoreboard: RTL and testbench

Issue-stage scoreboard for the dual-issue 7-stage RISCV pipeline. It tracks in-flight writes to the 32-entry, two-write-port register file. Each cycle it decides whether the older (slot 0) and younger (slot 1) instructions in the issue pair may issue, stalling them on RAW hazards, WAW hazards and intra-pair dependencies. Busy state is cleared by the two register-file writeback ports.

---
 rtl/riscv_core_reg_scoreboard.sv | 109 ++++++++++
 tb/tb_riscv_core_reg_scoreboard.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_reg_scoreboard.sv
// riscv_core_reg_scoreboard
//   Issue-stage register scoreboard for a dual-issue in-order pipeline.
//   It tracks in-flight writes to the 32-entry register file, which has two
//   write ports. Each cycle it grants or stalls the older (slot 0) and
//   younger (slot 1) instruction of the issue pair. The checks cover RAW
//   hazards, WAW hazards and dependencies inside the pair.
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   iss_val_0/1                slot holds a valid instruction
//   rs1_0/1, rs2_0/1           source register addresses
//   rs1_en_0/1, rs2_en_0/1     source is actually read
//   rd_0/1, rd_wen_0/1         destination address and write enable
//   lat_0/1                    extra cycles until the result can be bypassed
//   pipe_stall                 downstream stall; freezes issue and counters
//   wb_en_0/1, wb_addr_0/1     register-file write ports (clear busy)
//   go_0/1                     slot issues this cycle (combinational)
//   sb_busy                    registered busy vector; bit 0 is always 0
module riscv_core_reg_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        iss_val_0,
  input  logic [4:0]  rs1_0,
  input  logic [4:0]  rs2_0,
  input  logic        rs1_en_0,
  input  logic        rs2_en_0,
  input  logic [4:0]  rd_0,
  input  logic        rd_wen_0,
  input  logic [1:0]  lat_0,
  input  logic        iss_val_1,
  input  logic [4:0]  rs1_1,
  input  logic [4:0]  rs2_1,
  input  logic        rs1_en_1,
  input  logic        rs2_en_1,
  input  logic [4:0]  rd_1,
  input  logic        rd_wen_1,
  input  logic [1:0]  lat_1,
  input  logic        pipe_stall,
  input  logic        wb_en_0,
  input  logic [4:0]  wb_addr_0,
  input  logic        wb_en_1,
  input  logic [4:0]  wb_addr_1,
  output logic        go_0,
  output logic        go_1,
  output logic [31:0] sb_busy
);

  // busy[0] and cnt[0] are only ever reset. That keeps x0 permanently
  // free without a special case on the read side.
  logic [31:0] busy;
  logic [1:0]  cnt [32];

  logic raw_rs1_0, raw_rs2_0, waw_0;
  logic raw_rs1_1, raw_rs2_1, waw_1;
  logic intra;
  logic set_0, set_1;

  // A busy source with cnt == 0 is bypassable, so it does not stall.
  assign raw_rs1_0 = rs1_en_0 && (rs1_0 != '0) && busy[rs1_0] && (cnt[rs1_0] != '0);
  assign raw_rs2_0 = rs2_en_0 && (rs2_0 != '0) && busy[rs2_0] && (cnt[rs2_0] != '0);
  assign waw_0     = rd_wen_0 && (rd_0 != '0) && busy[rd_0];
  assign raw_rs1_1 = rs1_en_1 && (rs1_1 != '0) && busy[rs1_1] && (cnt[rs1_1] != '0);
  assign raw_rs2_1 = rs2_en_1 && (rs2_1 != '0) && busy[rs2_1] && (cnt[rs2_1] != '0);
  assign waw_1     = rd_wen_1 && (rd_1 != '0) && busy[rd_1];

  assign intra = rd_wen_0 && (rd_0 != '0) &&
                 ((rs1_en_1 && (rs1_1 == rd_0)) ||
                  (rs2_en_1 && (rs2_1 == rd_0)) ||
                  (rd_wen_1 && (rd_1 == rd_0)));

  // Slot 1 depends on go_0, so issue always stays in program order.
  assign go_0 = iss_val_0 && !pipe_stall && !raw_rs1_0 && !raw_rs2_0 && !waw_0;
  assign go_1 = iss_val_1 && go_0 && !raw_rs1_1 && !raw_rs2_1 && !waw_1 && !intra;

  assign set_0 = go_0 && rd_wen_0 && (rd_0 != '0);
  assign set_1 = go_1 && rd_wen_1 && (rd_1 != '0);

  assign sb_busy = busy;

  // Within one entry, later non-blocking assignments win. The issue set
  // therefore overrides a same-cycle writeback clear or decrement. The two
  // slots never set the same rd, because the intra-pair check blocks that.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
      for (int unsigned r = 0; r < 32; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int unsigned r = 1; r < 32; r++) begin
        if ((wb_en_0 && (wb_addr_0 == r[4:0])) || (wb_en_1 && (wb_addr_1 == r[4:0]))) begin
          busy[r] <= 1'b0;
          cnt[r]  <= '0;
        end else if (!pipe_stall && busy[r] && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - 2'd1;
        end
        if (set_0 && (rd_0 == r[4:0])) begin
          busy[r] <= 1'b1;
          cnt[r]  <= lat_0;
        end
        if (set_1 && (rd_1 == r[4:0])) begin
          busy[r] <= 1'b1;
          cnt[r]  <= lat_1;
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_reg_scoreboard.sv
// tb_riscv_core_reg_scoreboard
//   Directed bench for riscv_core_reg_scoreboard. A table holds one record
//   per cycle: the issue pair, the stall and writeback inputs, and the
//   expected go_0/go_1/sb_busy for that cycle. Hand-written sequences cover
//   reset asserted in the middle of a run.
module tb_riscv_core_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_val_0, rs1_en_0, rs2_en_0, rd_wen_0;
  logic [4:0]  rs1_0, rs2_0, rd_0;
  logic [1:0]  lat_0;
  logic        iss_val_1, rs1_en_1, rs2_en_1, rd_wen_1;
  logic [4:0]  rs1_1, rs2_1, rd_1;
  logic [1:0]  lat_1;
  logic        pipe_stall;
  logic        wb_en_0, wb_en_1;
  logic [4:0]  wb_addr_0, wb_addr_1;
  logic        go_0, go_1;
  logic [31:0] sb_busy;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  riscv_core_reg_scoreboard dut (
    .clk(clk), .reset(reset),
    .iss_val_0(iss_val_0), .rs1_0(rs1_0), .rs2_0(rs2_0),
    .rs1_en_0(rs1_en_0), .rs2_en_0(rs2_en_0), .rd_0(rd_0),
    .rd_wen_0(rd_wen_0), .lat_0(lat_0),
    .iss_val_1(iss_val_1), .rs1_1(rs1_1), .rs2_1(rs2_1),
    .rs1_en_1(rs1_en_1), .rs2_en_1(rs2_en_1), .rd_1(rd_1),
    .rd_wen_1(rd_wen_1), .lat_1(lat_1),
    .pipe_stall(pipe_stall),
    .wb_en_0(wb_en_0), .wb_addr_0(wb_addr_0),
    .wb_en_1(wb_en_1), .wb_addr_1(wb_addr_1),
    .go_0(go_0), .go_1(go_1), .sb_busy(sb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       e1;
    logic [4:0] rs2;
    logic       e2;
    logic [4:0] rd;
    logic       w;
    logic [1:0] lat;
  } ins_t;

  typedef struct {
    ins_t        i0;
    ins_t        i1;
    logic        stall;
    logic        wbe0;
    logic [4:0]  wba0;
    logic        wbe1;
    logic [4:0]  wba1;
    logic        g0;
    logic        g1;
    logic [31:0] busy;
  } vec_t;

  function automatic ins_t op(int rd, int w, int s1, int e1, int s2, int e2, int lat);
    ins_t x;
    x.v = 1'b1;  x.rd = 5'(rd);  x.w = (w != 0);
    x.rs1 = 5'(s1); x.e1 = (e1 != 0);
    x.rs2 = 5'(s2); x.e2 = (e2 != 0);
    x.lat = 2'(lat);
    return x;
  endfunction

  function automatic ins_t nop();
    ins_t x;
    x.v = 1'b0; x.rd = '0; x.w = 1'b0; x.rs1 = '0; x.e1 = 1'b0;
    x.rs2 = '0; x.e2 = 1'b0; x.lat = '0;
    return x;
  endfunction

  // rd = s1 op s2, result bypassable after lat extra cycles
  function automatic ins_t alu(int rd, int s1, int s2, int lat);
    return op(rd, 1, s1, 1, s2, 1, lat);
  endfunction

  // Reads one register and writes nothing, so a grant changes no state.
  function automatic ins_t probe(int s);
    return op(0, 0, s, 1, 0, 0, 0);
  endfunction

  function automatic logic [31:0] b(int r);
    return 32'd1 << r;
  endfunction

  function automatic vec_t mk(ins_t a, ins_t c, int st, int we0, int wa0, int we1, int wa1,
                              int g0, int g1, logic [31:0] bz);
    vec_t t;
    t.i0 = a; t.i1 = c; t.stall = (st != 0);
    t.wbe0 = (we0 != 0); t.wba0 = 5'(wa0);
    t.wbe1 = (we1 != 0); t.wba1 = 5'(wa1);
    t.g0 = (g0 != 0); t.g1 = (g1 != 0); t.busy = bz;
    return t;
  endfunction

  task automatic drive(vec_t t);
    iss_val_0 = t.i0.v; rs1_0 = t.i0.rs1; rs1_en_0 = t.i0.e1; rs2_0 = t.i0.rs2;
    rs2_en_0 = t.i0.e2; rd_0 = t.i0.rd; rd_wen_0 = t.i0.w; lat_0 = t.i0.lat;
    iss_val_1 = t.i1.v; rs1_1 = t.i1.rs1; rs1_en_1 = t.i1.e1; rs2_1 = t.i1.rs2;
    rs2_en_1 = t.i1.e2; rd_1 = t.i1.rd; rd_wen_1 = t.i1.w; lat_1 = t.i1.lat;
    pipe_stall = t.stall;
    wb_en_0 = t.wbe0; wb_addr_0 = t.wba0;
    wb_en_1 = t.wbe1; wb_addr_1 = t.wba1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  vec_t tbl[$];
  logic [31:0] m;

  initial begin
    // load-use
    tbl.push_back(mk(op(3,1,1,1,0,0,1), nop(), 0, 0,0, 0,0, 1,0, '0));
    tbl.push_back(mk(alu(4,3,1,0), nop(), 0, 0,0, 0,0, 0,0, b(3)));
    tbl.push_back(mk(alu(4,3,1,0), nop(), 0, 0,0, 0,0, 1,0, b(3)));
    tbl.push_back(mk(nop(), nop(), 0, 1,3, 1,4, 0,0, b(3)|b(4)));
    // intra-pair RAW, then the left-behind instruction shifted into slot 0
    tbl.push_back(mk(alu(7,1,2,0), alu(8,7,2,0), 0, 0,0, 0,0, 1,0, '0));
    tbl.push_back(mk(alu(8,7,2,0), nop(), 0, 1,7, 0,0, 1,0, b(7)));
    tbl.push_back(mk(alu(7,1,2,0), alu(9,1,2,0), 0, 1,8, 0,0, 1,1, b(8)));
    tbl.push_back(mk(nop(), nop(), 0, 1,7, 1,9, 0,0, b(7)|b(9)));
    // WAW on x10, released by write port 1
    tbl.push_back(mk(alu(10,1,2,0), nop(), 0, 0,0, 0,0, 1,0, '0));
    tbl.push_back(mk(alu(10,1,2,0), nop(), 0, 0,0, 0,0, 0,0, b(10)));
    tbl.push_back(mk(alu(10,1,2,0), nop(), 0, 0,0, 1,10, 0,0, b(10)));
    tbl.push_back(mk(alu(10,1,2,0), nop(), 0, 0,0, 0,0, 1,0, '0));
    tbl.push_back(mk(nop(), nop(), 0, 1,10, 0,0, 0,0, b(10)));
    // x0 write, then counters frozen by pipe_stall
    tbl.push_back(mk(alu(0,1,2,0), nop(), 0, 0,0, 0,0, 1,0, '0));
    tbl.push_back(mk(alu(6,1,2,2), nop(), 0, 0,0, 0,0, 1,0, '0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(probe(6), nop(), 1, 0,0, 0,0, 0,0, b(6)));
    tbl.push_back(mk(probe(6), nop(), 0, 0,0, 0,0, 0,0, b(6)));
    tbl.push_back(mk(probe(6), nop(), 0, 0,0, 0,0, 0,0, b(6)));
    tbl.push_back(mk(probe(6), nop(), 0, 0,0, 0,0, 1,0, b(6)));
    tbl.push_back(mk(probe(6), nop(), 1, 1,6, 0,0, 0,0, b(6)));
    tbl.push_back(mk(nop(), nop(), 0, 0,0, 0,0, 0,0, '0));
    // dual writeback collision on x12 with a stalled lat-3 issue
    tbl.push_back(mk(alu(12,1,2,0), nop(), 0, 0,0, 0,0, 1,0, '0));
    tbl.push_back(mk(alu(12,1,2,3), nop(), 0, 1,12, 1,12, 0,0, b(12)));
    tbl.push_back(mk(alu(12,1,2,3), nop(), 0, 0,0, 0,0, 1,0, '0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(probe(12), nop(), 0, 0,0, 0,0, 0,0, b(12)));
    tbl.push_back(mk(probe(12), nop(), 0, 0,0, 0,0, 1,0, b(12)));
    // slot 1 hazards
    tbl.push_back(mk(alu(14,1,2,1), nop(), 0, 0,0, 0,0, 1,0, b(12)));
    tbl.push_back(mk(alu(15,1,2,0), alu(16,14,1,0), 0, 0,0, 0,0, 1,0, b(12)|b(14)));
    tbl.push_back(mk(probe(14), alu(16,14,1,0), 0, 0,0, 0,0, 1,1, b(12)|b(14)|b(15)));
    m = b(12)|b(14)|b(15)|b(16);
    tbl.push_back(mk(alu(15,1,2,0), alu(18,1,2,0), 0, 0,0, 0,0, 0,0, m));
    tbl.push_back(mk(alu(20,1,2,0), alu(20,1,2,0), 0, 0,0, 0,0, 1,0, m));
    m = m | b(20);
    tbl.push_back(mk(alu(21,1,2,0), op(22,1,21,0,2,1,0), 0, 0,0, 0,0, 1,1, m));
    m = m | b(21) | b(22);
    tbl.push_back(mk(nop(), nop(), 0, 0,0, 0,0, 0,0, m));
    tbl.push_back(mk(alu(23,1,2,0), alu(16,1,2,0), 0, 0,0, 0,0, 1,0, m));
    m = m | b(23);
    tbl.push_back(mk(nop(), nop(), 0, 1,12, 1,14, 0,0, m));
    m = m & ~(b(12)|b(14));
    tbl.push_back(mk(nop(), nop(), 0, 0,0, 0,0, 0,0, m));

    reset = 1'b1;
    drive(mk(nop(), nop(), 0, 0,0, 0,0, 0,0, '0));
    #12 reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_busy", sb_busy, '0);
    chk("reset_go0", {31'd0, go_0}, 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("row%0d_go0", i), {31'd0, go_0}, {31'd0, tbl[i].g0});
      chk($sformatf("row%0d_go1", i), {31'd0, go_1}, {31'd0, tbl[i].g1});
      chk($sformatf("row%0d_busy", i), sb_busy, tbl[i].busy);
      @(posedge clk); #1;
    end

    // Mid-run asynchronous reset with x5 in flight (cnt = 2)
    drive(mk(alu(5,1,2,2), nop(), 0, 0,0, 0,0, 0,0, '0));
    @(negedge clk);
    chk("mid_issue_go0", {31'd0, go_0}, 32'd1);
    @(posedge clk); #1;
    drive(mk(nop(), nop(), 0, 0,0, 0,0, 0,0, '0));
    chk("mid_busy5_set", {31'd0, sb_busy[5]}, 32'd1);
    #2 reset = 1'b1;
    #1 chk("mid_reset_busy", sb_busy, '0);
    drive(mk(probe(5), nop(), 0, 0,0, 0,0, 0,0, '0));
    #1 chk("in_reset_go0", {31'd0, go_0}, 32'd1);
    drive(mk(alu(5,1,2,0), alu(8,5,1,0), 0, 0,0, 0,0, 0,0, '0));
    #1 chk("in_reset_pair_go0", {31'd0, go_0}, 32'd1);
    chk("in_reset_pair_go1", {31'd0, go_1}, 32'd0);
    drive(mk(probe(5), nop(), 1, 0,0, 0,0, 0,0, '0));
    #1 chk("in_reset_stall_go0", {31'd0, go_0}, 32'd0);
    drive(mk(probe(5), nop(), 0, 0,0, 0,0, 0,0, '0));
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    #1 chk("post_reset_go0", {31'd0, go_0}, 32'd1);
    chk("post_reset_busy", sb_busy, '0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
